// File: rtl/obj_tape_punch_pkg.sv
// obj_tape_punch_pkg: shared memory/tape definitions for the PAL binary tape dumper.
package obj_tape_punch_pkg;
    localparam int PAGES = 32;
    localparam int WORDS_PER_PAGE = 128;
    typedef logic [11:0] word;
    typedef logic [7:0] tape_frame_t;
    localparam tape_frame_t TAPE_ORIGIN_FLAG = 8'o100;
    localparam logic [5:0] TAPE_FIELD_MASK = 6'o77;
    typedef enum logic [3:0] {
        IDLE, REQ, WAIT, ORG_HI, ORG_LO, DAT_HI, DAT_LO, NEXT, FIN
    } Punch_states_t;
    function automatic tape_frame_t tape_field(input logic [5:0] f);
        return {2'b00, f & TAPE_FIELD_MASK};
    endfunction
endpackage

// File: rtl/obj_tape_punch_frame_tx.sv
// tape_frame_tx: single-entry output register holding a frame until the consumer accepts it.
module tape_frame_tx
    import obj_tape_punch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  tape_frame_t frame,
    input  logic        ready,
    output tape_frame_t data,
    output logic        valid,
    output logic        accept
);
    assign accept = valid & ready;
    // A load in the accept cycle refills the slot, giving one frame per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= frame;
            valid <= 1'b1;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/obj_tape_punch.sv
// obj_tape_punch: walks a PDP-8 address range over the memory read port and punches
// the PAL binary stream (origin records for each run of valid words, two frames per word).
module obj_tape_punch
    import obj_tape_punch_pkg::*;
#(
    parameter int ADDR_W = $clog2(PAGES * WORDS_PER_PAGE),
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              btnCpuReset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_valid,
    input  logic              mem_finished,
    output logic [7:0]        tape_data,
    output logic              tape_valid,
    input  logic              tape_ready,
    output logic              busy,
    output logic              done
);
    Punch_states_t state, next;
    logic [ADDR_W:0] cur, last;
    logic [DATA_W-1:0] data, wd;
    logic need_origin, load, accept;
    tape_frame_t frame;

    assign mem_read_enable = state == REQ || state == WAIT;
    assign mem_address = cur[ADDR_W-1:0];
    assign busy = state != IDLE && state != FIN;
    assign done = state == FIN;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = end_addr < start_addr ? FIN : REQ;
            REQ:     next = WAIT;
            WAIT:    if (mem_finished) next = !mem_valid ? NEXT : need_origin ? ORG_HI : DAT_HI;
            ORG_HI:  if (accept) next = ORG_LO;
            ORG_LO:  if (accept) next = DAT_HI;
            DAT_HI:  if (accept) next = DAT_LO;
            DAT_LO:  if (accept) next = NEXT;
            NEXT:    next = cur == last ? FIN : REQ;
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Frames are loaded on the edge that enters an emit state; the word comes
    // straight off the bus when leaving WAIT since data is captured on that edge.
    always_comb begin
        wd = state == WAIT ? mem_read_data : data;
        frame = next == ORG_HI ? (TAPE_ORIGIN_FLAG | tape_field(cur[ADDR_W-1 -: 6])) :
                next == ORG_LO ? tape_field(cur[5:0]) :
                next == DAT_HI ? tape_field(wd[DATA_W-1 -: 6]) : tape_field(wd[5:0]);
        load = next != state && (next inside {ORG_HI, ORG_LO, DAT_HI, DAT_LO});
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            cur <= '0;
            last <= '0;
            data <= '0;
            need_origin <= 1'b1;
        end else if (state == IDLE && start) begin
            cur <= {1'b0, start_addr};
            last <= {1'b0, end_addr};
            need_origin <= 1'b1;
        end else if (state == WAIT && mem_finished) begin
            data <= mem_read_data;
            if (!mem_valid) need_origin <= 1'b1;
        end else if (state == ORG_LO && accept) begin
            need_origin <= 1'b0;
        end else if (state == NEXT && cur != last) begin
            cur <= cur + 1'b1;
        end
    end

    tape_frame_tx u_tx (
        .clk    (clk),
        .rst_n  (btnCpuReset),
        .load   (load),
        .frame  (frame),
        .ready  (tape_ready),
        .data   (tape_data),
        .valid  (tape_valid),
        .accept (accept)
    );
endmodule

// File: tb/tb_obj_tape_punch.sv
// tb_obj_tape_punch: table-driven dumps against a latency-configurable memory model.
module tb_obj_tape_punch;
    logic clk = 0, btnCpuReset = 0, start = 0, tape_ready = 1;
    logic [11:0] start_addr = 0, end_addr = 0, mem_address, mem_read_data = 0;
    logic mem_read_enable, mem_valid = 0, mem_finished = 0, tape_valid, busy, done;
    logic [7:0] tape_data;
    int tests = 0, failed = 0;
    int lat = 0, mcnt = 0, reads = 0, hold_err = 0;
    logic [11:0] held = 0;
    logic [11:0] mem [4096];
    bit vld [4096];

    typedef struct {
        logic [11:0] sa, ea;
        int lat;
        bit rnd, spam, gap;
        logic [11:0] ga;
        int nf, nr;
        logic [0:7][7:0] f;
    } vec_t;
    vec_t v [9];
    string nm [9] = '{"contig", "gap", "backpressure", "top_addr", "end_lt_start",
                      "lat1", "lat7", "top_pair", "start_busy"};

    obj_tape_punch dut (
        .clk(clk), .btnCpuReset(btnCpuReset), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .mem_read_enable(mem_read_enable), .mem_address(mem_address),
        .mem_read_data(mem_read_data), .mem_valid(mem_valid), .mem_finished(mem_finished),
        .tape_data(tape_data), .tape_valid(tape_valid), .tape_ready(tape_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory model: strobes mem_finished lat cycles after the first WAIT cycle.
    always @(negedge clk) begin
        if (mem_read_enable) begin
            mcnt++;
            if (mcnt == 1) begin
                reads++;
                held = mem_address;
            end else if (mem_address != held) hold_err++;
            mem_finished = mcnt == lat + 2;
            mem_read_data = mem_finished ? mem[mem_address] : 12'o0;
            mem_valid = mem_finished && vld[mem_address];
        end else begin
            mcnt = 0;
            mem_finished = 0;
            mem_read_data = 0;
            mem_valid = 0;
        end
    end

    task automatic check(input string n, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0o expected %0o (octal)", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] sa, input logic [11:0] ea, input int l,
                                input bit rnd, input bit spam, input bit gap, input logic [11:0] ga,
                                input int nf, input int nr, input logic [0:7][7:0] f);
        vec_t r;
        r.sa = sa; r.ea = ea; r.lat = l; r.rnd = rnd; r.spam = spam; r.gap = gap;
        r.ga = ga; r.nf = nf; r.nr = nr; r.f = f;
        return r;
    endfunction

    task automatic apply(input vec_t t, input string n);
        logic [7:0] got [$];
        logic [7:0] pd = 0;
        int dn = 0, post = 0, stab = 0, cyc, r0, h0;
        bit hold = 0;
        lat = t.lat;
        if (t.gap) vld[t.ga] = 0;
        r0 = reads;
        h0 = hold_err;
        tape_ready = 1;
        @(negedge clk);
        start_addr = t.sa;
        end_addr = t.ea;
        start = 1;
        for (cyc = 0; cyc < 2000 && post < 3; cyc++) begin
            @(negedge clk);
            if (t.spam && dn == 0) begin
                start = 1;
                start_addr = 12'o0;
                end_addr = 12'o7777;
            end else start = 0;
            if (t.rnd) tape_ready = 1'($urandom_range(0, 1));
            #1;
            if (hold && (!tape_valid || tape_data != pd)) stab++;
            hold = tape_valid && !tape_ready;
            pd = tape_data;
            if (tape_valid && tape_ready) got.push_back(tape_data);
            if (done) dn++;
            if (dn > 0) post++;
        end
        start = 0;
        tape_ready = 1;
        if (t.gap) vld[t.ga] = 1;
        check({n, " finished_in_budget"}, cyc < 2000, 1);
        check({n, " done_pulses"}, dn, 1);
        check({n, " busy_after"}, busy, 0);
        check({n, " frame_count"}, got.size(), t.nf);
        for (int i = 0; i < t.nf; i++)
            check($sformatf("%s frame%0d", n, i), i < got.size() ? got[i] : -1, t.f[i]);
        check({n, " held_while_not_ready"}, stab, 0);
        check({n, " mem_reads"}, reads - r0, t.nr);
        check({n, " addr_hold"}, hold_err - h0, 0);
    endtask

    initial begin
        bit found = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 0;
            vld[i] = 1;
        end
        mem[12'o0200] = 12'o7200;
        mem[12'o0201] = 12'o1205;
        mem[12'o0202] = 12'o7402;
        mem[12'o7776] = 12'o0001;
        mem[12'o7777] = 12'o0017;
        v[0] = mk(12'o0200, 12'o0201, 0, 0, 0, 0, 0, 6, 2,
                  {8'o102, 8'o0, 8'o72, 8'o0, 8'o12, 8'o5, 8'o0, 8'o0});
        v[1] = mk(12'o0200, 12'o0202, 0, 0, 0, 1, 12'o0201, 8, 3,
                  {8'o102, 8'o0, 8'o72, 8'o0, 8'o102, 8'o2, 8'o74, 8'o2});
        v[2] = v[0];
        v[2].rnd = 1;
        v[3] = mk(12'o7777, 12'o7777, 0, 0, 0, 0, 0, 4, 1,
                  {8'o177, 8'o77, 8'o0, 8'o17, 8'o0, 8'o0, 8'o0, 8'o0});
        v[4] = mk(12'o0300, 12'o0200, 0, 0, 0, 0, 0, 0, 0, '0);
        v[5] = v[0];
        v[5].lat = 1;
        v[6] = v[0];
        v[6].lat = 7;
        v[7] = mk(12'o7776, 12'o7777, 0, 0, 0, 0, 0, 6, 2,
                  {8'o177, 8'o76, 8'o0, 8'o1, 8'o0, 8'o17, 8'o0, 8'o0});
        v[8] = v[0];
        v[8].spam = 1;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {mem_read_enable, mem_address, tape_data, tape_valid, busy, done}, 0);
        @(negedge clk);
        btnCpuReset = 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) apply(v[i], nm[i]);

        // Reset while the first data frame is being presented.
        lat = 0;
        @(negedge clk);
        start_addr = 12'o0200;
        end_addr = 12'o0201;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            #1;
            if (tape_valid && tape_data == 8'o072) found = 1;
            else @(negedge clk);
        end
        check("reached_dat_hi", found, 1);
        btnCpuReset = 0;
        #1;
        check("mid_dump_reset_outputs",
              {mem_read_enable, mem_address, tape_data, tape_valid, busy, done}, 0);
        @(negedge clk);
        btnCpuReset = 1;
        apply(v[0], "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
